aes_key_schedule: RTL and testbench



---
 rtl/aes_pkg.sv | 51 +++++
 rtl/aes_sbox.sv | 18 +
 rtl/aes_key_schedule.sv | 130 +++++++++++++
 tb/tb_aes_key_schedule.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared AES constants, key-schedule state type, round
//                constants and the FIPS-197 S-box lookup function.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int AES_NR    = 10;
    localparam int AES_KEY_W = 128;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_t;

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Entry 0x00 sits in the top byte; entry 0xff in the bottom byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Byte b lives at bits [8*(255-b)+7 -: 8], i.e. index {~b, 3'b111}.
    function automatic logic [7:0] aes_sbox_f(input logic [7:0] b);
        logic [10:0] idx;
        idx = {~b, 3'b111};
        return SBOX_TABLE[idx -: 8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
//  Module      : aes_sbox
//  Description : 8-bit combinational AES forward S-box (FIPS-197).
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    // Pure table lookup shared with the encrypt core through the package.
    assign o_byte = aes_sbox_f(i_byte);

endmodule
`default_nettype wire

// File: rtl/aes_key_schedule.sv
`default_nettype none
// ============================================================================
//  Module      : aes_key_schedule
//  Description : Iterative AES-128 key expansion, one round key per clock,
//                with a round-key register file, combinational read port and
//                a per-round valid bitmap.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_key_schedule
    import aes_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [AES_KEY_W-1:0] key,
    input  logic                 key_load,
    input  logic [3:0]           round_idx,
    output logic [AES_KEY_W-1:0] round_key,
    output logic [AES_NR:0]      round_valid,
    output logic                 busy,
    output logic                 ready
);

    state_t               r_state;
    state_t               w_state_next;
    logic [3:0]           r_cnt;
    logic [AES_KEY_W-1:0] r_rk [0:AES_NR];
    logic [AES_NR:0]      r_valid;

    logic [AES_KEY_W-1:0] w_prev;
    logic [AES_KEY_W-1:0] w_next;
    logic [7:0]           w_rc;
    logic [31:0]          w_rot;
    logic [31:0]          w_sub;
    logic [31:0]          w_t;
    logic [31:0]          w_q0, w_q1, w_q2, w_q3;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: a load always (re)starts expansion; round 10 ends it.
    always_comb begin
        w_state_next = r_state;
        if (key_load) begin
            w_state_next = EXPAND;
        end else if (r_state == EXPAND && r_cnt == 4'(AES_NR)) begin
            w_state_next = IDLE;
        end
    end

    // Outputs: ready is simply "every round key valid".
    always_comb begin
        busy        = (r_state == EXPAND);
        ready       = &r_valid;
        round_valid = r_valid;
    end

    // Select the previous round key and round constant for the current step.
    always_comb begin
        w_prev = '0;
        w_rc   = '0;
        for (int i = 1; i <= AES_NR; i++) begin
            if (r_cnt == 4'(i)) begin
                w_prev = r_rk[i-1];
                w_rc   = RCON[i];
            end
        end
    end

    assign w_rot = {w_prev[23:0], w_prev[31:24]};

    generate
        for (genvar g = 0; g < 4; g++) begin : g_sbox
            aes_sbox u_sbox (
                .i_byte (w_rot[8*g +: 8]),
                .o_byte (w_sub[8*g +: 8])
            );
        end
    endgenerate

    // Round function: word chain driven by SubWord(RotWord(p3)) ^ Rcon.
    always_comb begin
        w_t    = w_sub ^ {w_rc, 24'h0};
        w_q0   = w_prev[127:96] ^ w_t;
        w_q1   = w_prev[95:64]  ^ w_q0;
        w_q2   = w_prev[63:32]  ^ w_q1;
        w_q3   = w_prev[31:0]   ^ w_q2;
        w_next = {w_q0, w_q1, w_q2, w_q3};
    end

    // Register file, round counter and valid bitmap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_valid <= '0;
            for (int i = 0; i <= AES_NR; i++) begin
                r_rk[i] <= '0;
            end
        end else if (key_load) begin
            r_rk[0] <= key;
            r_valid <= (AES_NR+1)'(1);
            r_cnt   <= 4'd1;
        end else if (r_state == EXPAND) begin
            for (int i = 1; i <= AES_NR; i++) begin
                if (r_cnt == 4'(i)) begin
                    r_rk[i]    <= w_next;
                    r_valid[i] <= 1'b1;
                end
            end
            r_cnt <= (r_cnt == 4'(AES_NR)) ? 4'd0 : r_cnt + 4'd1;
        end
    end

    // Combinational read port; indices past round 10 read as zero.
    always_comb begin
        round_key = '0;
        for (int i = 0; i <= AES_NR; i++) begin
            if (round_idx == 4'(i)) begin
                round_key = r_rk[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_key_schedule.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_key_schedule
//  Description : Self-checking bench for aes_key_schedule against an
//                independent FIPS-197 word-oriented key expansion model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_key_schedule;

    logic         clk;
    logic         reset_n;
    logic [127:0] key;
    logic         key_load;
    logic [3:0]   round_idx;
    logic [127:0] round_key;
    logic [10:0]  round_valid;
    logic         busy;
    logic         ready;

    int n_tests;
    int n_fail;

    logic [7:0]   m_sbox [256];
    logic [127:0] m_rk   [11];
    int           m_k;

    aes_key_schedule dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .key         (key),
        .key_load    (key_load),
        .round_idx   (round_idx),
        .round_key   (round_key),
        .round_valid (round_valid),
        .busy        (busy),
        .ready       (ready)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] a;
        for (int i = 0; i < 256; i++) begin
            a   = 8'(i);
            inv = 8'h00;
            for (int j = 1; j < 256; j++) begin
                if (gmul(a, 8'(j)) == 8'h01) inv = 8'(j);
            end
            m_sbox[i] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {m_sbox[w[31:24]], m_sbox[w[23:16]], m_sbox[w[15:8]], m_sbox[w[7:0]]};
    endfunction

    // Classic 44-word expansion, Rcon generated by repeated doubling.
    task automatic model_expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        w[0] = k[127:96]; w[1] = k[95:64]; w[2] = k[63:32]; w[3] = k[31:0];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) begin
            m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    endtask

    task automatic model_reset();
        m_k = -1;
        for (int r = 0; r < 11; r++) m_rk[r] = '0;
    endtask

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: inputs seen at the edge update the model; key_load is a pulse.
    task automatic tick();
        logic         ld;
        logic [127:0] kk;
        ld = key_load;
        kk = key;
        @(posedge clk);
        #1;
        key_load = 1'b0;
        if (ld) begin
            m_k = 0;
            model_expand(kk);
        end else if (m_k >= 0 && m_k < 10) begin
            m_k++;
        end
    endtask

    // Compare status outputs and every readable index against the model.
    task automatic check_all(input string tag);
        logic [10:0] ev;
        ev = (m_k < 0) ? 11'h000 : 11'((12'h001 << (m_k + 1)) - 12'h001);
        chk({tag, "_valid"}, 128'(round_valid), 128'(ev));
        chk({tag, "_busy"},  128'(busy),  128'(m_k >= 0 && m_k < 10));
        chk({tag, "_ready"}, 128'(ready), 128'(m_k == 10));
        for (int r = 0; r < 16; r++) begin
            round_idx = 4'(r);
            #1;
            if (r > 10 || m_k < 0)
                chk($sformatf("%s_rk%0d", tag, r), round_key, 128'h0);
            else if (ev[r])
                chk($sformatf("%s_rk%0d", tag, r), round_key, m_rk[r]);
        end
        round_idx = 4'd0;
    endtask

    task automatic read_rk(input int r, output logic [127:0] v);
        round_idx = 4'(r);
        #1;
        v = round_key;
    endtask

    logic [127:0] v;

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset_n   = 1'b0;
        key       = '0;
        key_load  = 1'b0;
        round_idx = 4'd0;
        build_sbox();
        model_reset();
        #2;
        check_all("reset");
        #10;
        reset_n = 1'b1;

        // FIPS-197 A.1 key, bitmap progression checked every cycle.
        key      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        key_load = 1'b1;
        tick();
        check_all("a1_c0");
        for (int c = 1; c <= 10; c++) begin
            tick();
            check_all($sformatf("a1_c%0d", c));
        end
        read_rk(0,  v); chk("a1_fips_rk0",  v, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        read_rk(1,  v); chk("a1_fips_rk1",  v, 128'ha0fafe1788542cb123a339392a6c7605);
        read_rk(2,  v); chk("a1_fips_rk2",  v, 128'hf2c295f27a96b9435935807a7359f67f);
        read_rk(10, v); chk("a1_fips_rk10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        tick();
        check_all("a1_hold");

        // All-zero key, loaded while ready is high.
        key      = '0;
        key_load = 1'b1;
        tick();
        check_all("zero_c0");
        for (int c = 1; c <= 10; c++) tick();
        check_all("zero_done");
        read_rk(1,  v); chk("zero_fips_rk1",  v, 128'h62636363626363636263636362636363);
        read_rk(10, v); chk("zero_fips_rk10", v, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // Restart mid-expansion: A.1 then zero key four cycles later.
        key      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        key_load = 1'b1;
        tick();
        for (int c = 1; c <= 3; c++) tick();
        check_all("rst_a1_c3");
        key      = '0;
        key_load = 1'b1;
        tick();
        check_all("restart_c0");
        for (int c = 1; c <= 10; c++) begin
            tick();
            check_all($sformatf("restart_c%0d", c));
        end

        // key_load held high: each sample restarts.
        for (int h = 0; h < 3; h++) begin
            key      = {$urandom, $urandom, $urandom, $urandom};
            key_load = 1'b1;
            tick();
            check_all($sformatf("held_%0d", h));
        end
        for (int c = 1; c <= 10; c++) begin
            tick();
            check_all($sformatf("held_c%0d", c));
        end

        // Asynchronous reset between edges mid-expansion.
        key      = {$urandom, $urandom, $urandom, $urandom};
        key_load = 1'b1;
        tick();
        for (int c = 1; c <= 4; c++) tick();
        #4;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_all($sformatf("post_rst_%0d", c));
        end

        // Random keys through full expansion.
        for (int n = 0; n < 8; n++) begin
            key      = {$urandom, $urandom, $urandom, $urandom};
            key_load = 1'b1;
            tick();
            for (int c = 1; c <= 10; c++) tick();
            check_all($sformatf("rand%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
